// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-select encodings for the Avalon bidirectional PIO.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Pad input synchroniser with a one-cycle history register and per-bit edge pulses.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = o_sync & ~r_prev;
  assign w_fall = ~o_sync & r_prev;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign o_edge = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign o_edge = w_fall;
    end else begin : g_any
      assign o_edge = w_rise | w_fall;
    end
  endgenerate

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, synchronised input, edge capture, masked irq.
// Optional OUTSET/OUTCLR registers at addresses 4/5 are built when PIO_BITSET_EN is defined.
module avalon_bidir_pio
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             r_irq;
  logic [31:0]      r_rd;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [31:0]      w_rd_mux;

  assign w_wr  = chipselect & ~write_n;
  assign w_wd  = writedata[WIDTH-1:0];
  assign w_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pin   (bidir_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_sync;
      ADDR_DIR:     w_rd_mux[WIDTH-1:0] = r_dir;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_cap;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out  <= RESET_OUT;
      r_dir  <= RESET_DIR;
      r_mask <= '0;
      r_cap  <= '0;
      r_irq  <= 1'b0;
      r_rd   <= '0;
    end else begin
      if (w_wr && address == ADDR_DATA) r_out <= w_wd;
`ifdef PIO_BITSET_EN
      else if (w_wr && address == ADDR_OUTSET) r_out <= r_out | w_wd;
      else if (w_wr && address == ADDR_OUTCLR) r_out <= r_out & ~w_wd;
`endif
      if (w_wr && address == ADDR_DIR)     r_dir  <= w_wd;
      if (w_wr && address == ADDR_IRQMASK) r_mask <= w_wd;
      // A detect in the same cycle as its clear must survive, so the set term is ORed last.
      r_cap <= (r_cap & ~w_clr) | w_edge;
      r_irq <= |(r_cap & r_mask);
      r_rd  <= w_rd_mux;
    end
  end

  assign readdata = r_rd;
  assign irq      = r_irq;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
      assign bidir_port[g] = r_dir[g] ? r_out[g] : 1'bz;
    end
  endgenerate

endmodule

// File: tb/tb_avalon_bidir_pio.sv
// Randomised and directed bench for avalon_bidir_pio against a cycle-level behavioural model.
module tb_avalon_bidir_pio;
  import avalon_pio_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int ET = EDGE_RISE;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  wire  [W-1:0]  pads;
  logic [W-1:0]  tb_drv;
  logic [W-1:0]  tb_en;

  always #5 clk = ~clk;

  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pads[g] = tb_en[g] ? tb_drv[g] : 1'bz;
  end

  avalon_bidir_pio #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .EDGE_TYPE   (ET),
    .RESET_OUT   ('0),
    .RESET_DIR   ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (pads)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Register-level model; hist[k] is the pad value sampled k edges ago (hist[0] newest).
  logic [W-1:0] m_out, m_dir, m_mask, m_cap;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [$];

  task automatic model_reset();
    m_out  = '0;
    m_dir  = '0;
    m_mask = '0;
    m_cap  = '0;
    m_irq  = 1'b0;
    m_rd   = '0;
    hist   = {};
    repeat (S + 1) hist.push_back('0);
  endtask

  task automatic cyc(input logic rn, input logic cs, input logic wn, input logic [2:0] a,
                     input logic [31:0] wd, input logic [W-1:0] drv);
    logic [W-1:0] pad_now, sy, pv, edg, n_cap, n_out, wdw;
    logic [31:0]  n_rd;
    logic         wr;
    @(negedge clk);
    reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd;
    tb_drv = drv; tb_en = ~m_dir;
    #1;
    if (|m_dir) check_eq("pad_out", 32'(pads & m_dir), 32'(m_out & m_dir));
    pad_now = (m_dir & m_out) | (~m_dir & drv);
    wr  = cs & ~wn;
    wdw = wd[W-1:0];
    sy  = hist[S-1];
    pv  = hist[S];
    case (ET)
      EDGE_RISE: edg = sy & ~pv;
      EDGE_FALL: edg = ~sy & pv;
      default:   edg = sy ^ pv;
    endcase
    case (a)
      ADDR_DATA:    n_rd = 32'(sy);
      ADDR_DIR:     n_rd = 32'(m_dir);
      ADDR_IRQMASK: n_rd = 32'(m_mask);
      ADDR_EDGECAP: n_rd = 32'(m_cap);
      default:      n_rd = 32'd0;
    endcase
    n_cap = (wr && a == ADDR_EDGECAP) ? ((m_cap & ~wdw) | edg) : (m_cap | edg);
    n_out = m_out;
    if (wr && a == ADDR_DATA) n_out = wdw;
`ifdef PIO_BITSET_EN
    if (wr && a == ADDR_OUTSET) n_out = m_out | wdw;
    if (wr && a == ADDR_OUTCLR) n_out = m_out & ~wdw;
`endif
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
    end else begin
      m_irq = |(m_cap & m_mask);
      m_rd  = n_rd;
      m_cap = n_cap;
      m_out = n_out;
      if (wr && a == ADDR_DIR)     m_dir  = wdw;
      if (wr && a == ADDR_IRQMASK) m_mask = wdw;
      hist.push_front(pad_now);
      void'(hist.pop_back());
    end
    check_eq("rd", readdata, m_rd);
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [W-1:0] drv);
    cyc(1'b1, 1'b1, 1'b0, a, wd, drv);
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [W-1:0] drv);
    cyc(1'b1, 1'b0, 1'b1, a, 32'd0, drv);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
    writedata = '0; tb_drv = '0; tb_en = '1;
    model_reset();

    // Reset, with a write presented during reset that must be discarded
    cyc(1'b0, 1'b1, 1'b0, ADDR_DIR, 32'hFF, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, ADDR_DATA, 32'd0, 8'h00);
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    rd_reg(ADDR_DIR, 8'h00);
    rd_reg(ADDR_DIR, 8'h00);
    check_eq("rst_dir_read", readdata, 32'd0);

    // Low nibble driven, high nibble input; loopback on DATA
    wr_reg(ADDR_DIR, 32'h0F, 8'h00);
    wr_reg(ADDR_DATA, 32'hFFFF_FFA5, 8'h00);
    check_eq("t2_pad_lo", 32'(pads[3:0]), 32'h5);
    repeat (S + 2) rd_reg(ADDR_DATA, 8'h00);
    check_eq("t2_loopback_lo", readdata & 32'hF, 32'h5);

    // External drive of [7:4]=0xC: visible exactly S+1 clocks after the change
    wr_reg(ADDR_DIR, 32'h00, 8'h00);
    repeat (4) rd_reg(ADDR_DATA, 8'h00);
    for (int k = 0; k < S; k++) rd_reg(ADDR_DATA, 8'hC0);
    check_eq("t3_not_early", readdata, 32'h00);
    rd_reg(ADDR_DATA, 8'hC0);
    check_eq("t3_latency", readdata, 32'hC0);

    // Rising edge on pin 6, mask, irq, W1C
    wr_reg(ADDR_EDGECAP, 32'hFF, 8'hC0);
    repeat (4) rd_reg(ADDR_DATA, 8'h00);
    wr_reg(ADDR_EDGECAP, 32'hFF, 8'h00);
    for (int k = 0; k < S + 3; k++) rd_reg(ADDR_EDGECAP, 8'h40);
    check_eq("t4_edgecap", readdata, 32'h40);
    wr_reg(ADDR_IRQMASK, 32'h40, 8'h40);
    rd_reg(ADDR_EDGECAP, 8'h40);
    check_eq("t4_irq_set", 32'(irq), 32'd1);
    wr_reg(ADDR_EDGECAP, 32'h40, 8'h40);
    rd_reg(ADDR_EDGECAP, 8'h40);
    rd_reg(ADDR_EDGECAP, 8'h40);
    check_eq("t4_cleared", readdata, 32'h00);
    check_eq("t4_irq_clr", 32'(irq), 32'd0);

    // New edge detected in the same cycle as its W1C: set wins
    repeat (4) rd_reg(ADDR_DATA, 8'h00);
    for (int k = 0; k < S + 3; k++) rd_reg(ADDR_EDGECAP, 8'h40);
    repeat (4) rd_reg(ADDR_DATA, 8'h00);
    rd_reg(ADDR_DATA, 8'h40);
    for (int k = 0; k < S - 1; k++) rd_reg(ADDR_DATA, 8'h40);
    wr_reg(ADDR_EDGECAP, 32'h40, 8'h40);
    rd_reg(ADDR_EDGECAP, 8'h40);
    rd_reg(ADDR_EDGECAP, 8'h40);
    check_eq("t5_set_wins", readdata, 32'h40);
    check_eq("t5_irq_held", 32'(irq), 32'd1);

    // Bit set/clear aliases
    wr_reg(ADDR_EDGECAP, 32'hFF, 8'h00);
    wr_reg(ADDR_IRQMASK, 32'h00, 8'h00);
    wr_reg(ADDR_DIR, 32'hFF, 8'h00);
    wr_reg(ADDR_DATA, 32'h0F, 8'h00);
    wr_reg(ADDR_OUTSET, 32'h30, 8'h00);
    wr_reg(ADDR_OUTCLR, 32'h01, 8'h00);
    for (int k = 0; k < S + 2; k++) rd_reg(ADDR_DATA, 8'h00);
`ifdef PIO_BITSET_EN
    check_eq("t6_bitset_pads", 32'(pads), 32'h3E);
    check_eq("t6_bitset_read", readdata, 32'h3E);
`else
    check_eq("t6_bitset_pads", 32'(pads), 32'h0F);
    check_eq("t6_bitset_read", readdata, 32'h0F);
`endif
    rd_reg(3'd4, 8'h00);
    rd_reg(3'd7, 8'h00);
    check_eq("reserved_read", readdata, 32'h0);

    // Random traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
          3'($urandom_range(0, 7)), $urandom, W'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
